// File: rtl/tuner_seq_if.sv
// tuner_seq_if: sequencer handshake, stage memory ports and memory-side bus for tuner_seq_ctrl.
interface tuner_seq_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 10
);
  logic start, busy, done, error, mem_clr;
  logic [2:0] stage;
  logic load_go, load_done, fft_go, fft_done, freq_go, freq_done;
  logic load_we, fft_we, mem_we;
  logic [ADDR_W-1:0] load_addr, fft_addr, freq_addr, mem_addr;
  logic [DATA_W-1:0] load_wdata, fft_wdata, mem_wdata;
  modport master (
    input  start, load_done, fft_done, freq_done,
    input  load_addr, load_we, load_wdata, fft_addr, fft_we, fft_wdata, freq_addr,
    output busy, done, error, stage, load_go, fft_go, freq_go,
    output mem_addr, mem_we, mem_wdata, mem_clr
  );
  modport slave (
    output start, load_done, fft_done, freq_done,
    output load_addr, load_we, load_wdata, fft_addr, fft_we, fft_wdata, freq_addr,
    input  busy, done, error, stage, load_go, fft_go, freq_go,
    input  mem_addr, mem_we, mem_wdata, mem_clr
  );
endinterface

// File: rtl/tuner_seq_ctrl.sv
// tuner_seq_ctrl: run sequencer (clear, load, fft, freq) with watchdog and shared memory port mux.
// Optional SEQ_CONTINUOUS_EN: free-running runs until a start pulse while busy requests a stop.
module tuner_seq_ctrl #(
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 10,
  parameter int TIMEOUT = 100000,
  parameter int TO_W    = 17
) (
  input logic clk,
  input logic rst,
  tuner_seq_if.master bus
);
  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, FFT, FREQ, DONE, ERROR} state_t;
  state_t state, nxt;
  logic [TO_W-1:0] wd;
  logic [2:0] stage_nxt;
  logic go_any, done_in, tmo, run;
`ifdef SEQ_CONTINUOUS_EN
  logic stop_req, stop_nxt;
`endif
  always_comb begin
    run = state inside {CLEAR, LOAD, FFT, FREQ};
    go_any = bus.load_go | bus.fft_go | bus.freq_go;
    done_in = (bus.load_go & bus.load_done) | (bus.fft_go & bus.fft_done) | (bus.freq_go & bus.freq_done);
    tmo = (TIMEOUT != 0) && go_any && (wd == TO_W'(TIMEOUT - 1));
    nxt = state;
    case (state)
      IDLE:    nxt = bus.start ? CLEAR : IDLE;
      CLEAR:   nxt = LOAD;
      LOAD:    nxt = done_in ? FFT : tmo ? ERROR : LOAD;
      FFT:     nxt = done_in ? FREQ : tmo ? ERROR : FFT;
      FREQ:    nxt = done_in ? DONE : tmo ? ERROR : FREQ;
`ifdef SEQ_CONTINUOUS_EN
      DONE:    nxt = stop_req ? IDLE : CLEAR;
`else
      DONE:    nxt = IDLE;
`endif
      ERROR:   nxt = bus.start ? CLEAR : ERROR;
      default: nxt = IDLE;
    endcase
    stage_nxt = (nxt == CLEAR || nxt == LOAD) ? 3'd1 : nxt == FFT ? 3'd2 : nxt == FREQ ? 3'd3 :
                nxt == DONE ? 3'd4 : nxt == ERROR ? 3'd7 : 3'd0;
`ifdef SEQ_CONTINUOUS_EN
    stop_nxt = ((state inside {IDLE, ERROR}) && bus.start) || (state == DONE && stop_req) ? 1'b0 :
               (run && bus.start) ? 1'b1 : stop_req;
`endif
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      wd <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.error <= 1'b0;
      bus.mem_clr <= 1'b0;
      bus.stage <= 3'd0;
      bus.load_go <= 1'b0;
      bus.fft_go <= 1'b0;
      bus.freq_go <= 1'b0;
    end else begin
      state <= nxt;
      wd <= (go_any && nxt == state) ? wd + 1'b1 : '0;
      bus.busy <= nxt inside {CLEAR, LOAD, FFT, FREQ};
      bus.done <= nxt == DONE;
      bus.error <= nxt == ERROR;
      bus.mem_clr <= nxt == CLEAR;
      bus.stage <= stage_nxt;
      bus.load_go <= state == LOAD && nxt == LOAD;
      bus.fft_go <= state == FFT && nxt == FFT;
      bus.freq_go <= state == FREQ && nxt == FREQ;
    end
  end
`ifdef SEQ_CONTINUOUS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stop_req <= 1'b0;
    else stop_req <= stop_nxt;
  end
`endif
  // The port follows the state itself, so the settle cycle already belongs to the new stage.
  always_comb begin
    bus.mem_addr = state == LOAD ? bus.load_addr : state == FFT ? bus.fft_addr :
                   state == FREQ ? bus.freq_addr : '0;
    bus.mem_we = state == LOAD ? bus.load_we : state == FFT ? bus.fft_we : 1'b0;
    bus.mem_wdata = state == LOAD ? bus.load_wdata : state == FFT ? bus.fft_wdata : '0;
  end
endmodule

// File: tb/tb_tuner_seq_ctrl.sv
// tb_tuner_seq_ctrl: randomized stage stubs checked against a per-cycle timeline model of a run.
module tb_tuner_seq_ctrl;
  localparam int AW = 11;
  localparam int DW = 10;
  localparam int TO = 20;
`ifdef SEQ_CONTINUOUS_EN
  localparam int STOP = 2;
`else
  localparam int STOP = 0;
`endif
  typedef struct packed {
    logic [2:0] stage;
    logic busy, done, error, clr;
    logic [2:0] go;
    logic [1:0] own;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  tuner_seq_if #(.ADDR_W(AW), .DATA_W(DW)) sif ();
  tuner_seq_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .TO_W(17)) dut (
    .clk(clk), .rst(rst), .bus(sif)
  );
  // Expected outputs r cycles after the start pulse: CLEAR at 1, then each stage is one
  // settle cycle plus its go window, ending in DONE or, on a missing done, in ERROR.
  function automatic exp_t model(input int r, l0, l1, l2, input bit perr);
    exp_t e;
    int ln[3];
    int b, n;
    e = '0;
    ln = '{l0, l1, l2};
    if (r <= 0) begin
      e.stage = perr ? 3'd7 : 3'd0;
      e.error = perr;
      return e;
    end
    if (r == 1) begin
      e.busy = 1'b1;
      e.clr = 1'b1;
      e.stage = 3'd1;
      return e;
    end
    b = 2;
    for (int k = 0; k < 3; k++) begin
      n = (ln[k] == 0 || ln[k] > TO) ? TO : ln[k];
      if (r >= b && r <= b + n) begin
        e.stage = 3'(k + 1);
        e.busy = 1'b1;
        e.own = 2'(k + 1);
        if (r > b) e.go[k] = 1'b1;
        return e;
      end
      if (n != ln[k]) begin
        e.stage = 3'd7;
        e.error = 1'b1;
        return e;
      end
      b = b + n + 1;
    end
    if (r == b) begin
      e.done = 1'b1;
      e.stage = 3'd4;
    end
    return e;
  endfunction
  task automatic clear_inputs;
    sif.start = 1'b0;
    sif.load_done = 1'b0;
    sif.fft_done = 1'b0;
    sif.freq_done = 1'b0;
    sif.load_addr = '0;
    sif.load_we = 1'b0;
    sif.load_wdata = '0;
    sif.fft_addr = '0;
    sif.fft_we = 1'b0;
    sif.fft_wdata = '0;
    sif.freq_addr = '0;
  endtask
  task automatic run(input string name, input int l0, l1, l2, input bit perr, noise, wemode,
                     input int nruns, stop_at, extra);
    int ln[3];
    int b[4];
    int n[3];
    bit to;
    int p, last, r;
    exp_t e;
    logic [2:0] dv;
    logic [9:0] got, want;
    logic [AW+DW:0] gm, wm;
    ln = '{l0, l1, l2};
    b[0] = 2;
    to = 1'b0;
    p = 0;
    for (int k = 0; k < 3; k++) begin
      n[k] = (ln[k] == 0 || ln[k] > TO) ? TO : ln[k];
      b[k+1] = b[k] + n[k] + 1;
      if (!to && n[k] != ln[k]) begin
        to = 1'b1;
        p = b[k] + TO + 1;
      end
    end
    if (!to) p = b[3];
    last = to ? p + extra : nruns * p + extra;
    for (int i = 0; i <= last; i++) begin
      r = (i == 0) ? 0 : to ? i : (i <= nruns * p) ? ((i - 1) % p) + 1 : p + 1;
      sif.start = (i == 0) || (i == stop_at) || (noise && r >= 1 && r < p && $urandom_range(7) == 0);
      for (int k = 0; k < 3; k++)
        dv[k] = (r > b[k] && r <= b[k] + n[k]) ? (r == b[k] + ln[k]) : (noise && $urandom_range(3) == 0);
      sif.load_done = dv[0];
      sif.fft_done = dv[1];
      sif.freq_done = dv[2];
      sif.load_addr = AW'($urandom);
      sif.load_we = wemode ? 1'b1 : 1'($urandom);
      sif.load_wdata = DW'($urandom);
      sif.fft_addr = wemode ? 11'h155 : AW'($urandom);
      sif.fft_we = wemode ? 1'b1 : 1'($urandom);
      sif.fft_wdata = DW'($urandom);
      sif.freq_addr = AW'($urandom);
      @(negedge clk);
      e = model(r, l0, l1, l2, perr && i == 0);
      want = {e.stage, e.busy, e.done, e.error, e.clr, e.go};
      got = {sif.stage, sif.busy, sif.done, sif.error, sif.mem_clr, sif.freq_go, sif.fft_go, sif.load_go};
      checks++;
      if (r == 1 ? got[6:0] !== want[6:0] : got !== want) begin
        errors++;
        $display("FAIL %s ctrl i=%0d got %b want %b (stage,busy,done,error,clr,go[2:0])", name, i, got, want);
      end
      wm = e.own == 2'd1 ? {sif.load_addr, sif.load_we, sif.load_wdata} :
           e.own == 2'd2 ? {sif.fft_addr, sif.fft_we, sif.fft_wdata} :
           e.own == 2'd3 ? {sif.freq_addr, 1'b0, {DW{1'b0}}} : '0;
      gm = {sif.mem_addr, sif.mem_we, sif.mem_wdata};
      checks++;
      if (gm !== wm) begin
        errors++;
        $display("FAIL %s mux i=%0d got %h want %h", name, i, gm, wm);
      end
      @(posedge clk);
      #1;
    end
    clear_inputs();
  endtask
  task automatic test_reset;
    clear_inputs();
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({sif.stage, sif.busy, sif.done, sif.error, sif.mem_clr, sif.load_go, sif.fft_go, sif.freq_go,
         sif.mem_we, sif.mem_addr, sif.mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_async stage=%0d busy=%b go=%b%b%b mem_we=%b want all 0", sif.stage, sif.busy,
               sif.load_go, sif.fft_go, sif.freq_go, sif.mem_we);
    end
    sif.start = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({sif.stage, sif.busy, sif.mem_clr, sif.error} !== '0) begin
      errors++;
      $display("FAIL reset_hold stage=%0d busy=%b clr=%b error=%b want 0", sif.stage, sif.busy, sif.mem_clr, sif.error);
    end
    sif.start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask
  task automatic test_async_reset;
    sif.start = 1'b1;
    sif.load_done = 1'b1;
    sif.fft_we = 1'b1;
    sif.fft_addr = 11'h155;
    @(posedge clk);
    #1 sif.start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({sif.fft_go, sif.mem_we, sif.stage} !== {1'b1, 1'b1, 3'd2}) begin
      errors++;
      $display("FAIL async_pre fft_go=%b mem_we=%b stage=%0d want 1 1 2", sif.fft_go, sif.mem_we, sif.stage);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({sif.load_go, sif.fft_go, sif.freq_go, sif.mem_we, sif.error, sif.busy, sif.stage, sif.mem_addr} !== '0) begin
      errors++;
      $display("FAIL async_rst go=%b%b%b mem_we=%b error=%b stage=%0d addr=%h want 0", sif.load_go, sif.fft_go,
               sif.freq_go, sif.mem_we, sif.error, sif.stage, sif.mem_addr);
    end
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask
  task automatic test_nominal;
    run("nominal", 5, 5, 5, 1'b0, 1'b0, 1'b0, 1, STOP, 3);
  endtask
  task automatic test_mux;
    run("mux", 4, 6, 3, 1'b0, 1'b0, 1'b1, 1, STOP, 3);
  endtask
  task automatic test_timeout;
    run("timeout", 4, 0, 5, 1'b0, 1'b0, 1'b0, 1, STOP, 4);
    run("restart", 3, 3, 3, 1'b1, 1'b0, 1'b0, 1, STOP, 3);
  endtask
  task automatic test_done_wins;
    run("done_wins", 2, 20, 1, 1'b0, 1'b0, 1'b0, 1, STOP, 3);
  endtask
  task automatic test_ignore;
    run("ignore", 6, 5, 4, 1'b0, 1'b1, 1'b0, 1, 11, 3);
  endtask
  task automatic test_random;
    bit perr;
    int l[3];
    perr = 1'b0;
    for (int t = 0; t < 10; t++) begin
      for (int k = 0; k < 3; k++) l[k] = $urandom_range(0, 23);
      run("random", l[0], l[1], l[2], perr, 1'b1, 1'b0, 1, STOP, 3);
      perr = 1'b0;
      for (int k = 0; k < 3; k++) if (l[k] == 0 || l[k] > TO) perr = 1'b1;
    end
    if (perr) run("random_exit", 2, 2, 2, 1'b1, 1'b0, 1'b0, 1, STOP, 3);
  endtask
`ifdef SEQ_CONTINUOUS_EN
  task automatic test_continuous;
    run("continuous", 3, 4, 2, 1'b0, 1'b0, 1'b0, 2, 14 + 3, 4);
  endtask
`endif
  initial begin
    test_reset();
    test_nominal();
    test_mux();
    test_timeout();
    test_done_wins();
    test_ignore();
    test_async_reset();
    test_random();
`ifdef SEQ_CONTINUOUS_EN
    test_continuous();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tuner_seq_ctrl.md
Name: tuner_seq_ctrl

Overview:
Run-level sequencer and single-port memory owner for the tuner pipeline. On a start pulse it clears the sample memory, then runs three stages in order: load_to_mem, fft, find_freq. Each stage uses a go/done handshake. The block muxes the one shared memory port to the active stage only. It adds a per-stage watchdog, a sticky error flag and a stage code for display_result.

Parameters:
ADDR_W, 11, memory address width
DATA_W, 10, memory data width
TIMEOUT, 100000, max cycles per stage with go high; 0 disables watchdog
TO_W, 17, watchdog counter width; must hold TIMEOUT

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle request to begin a run
busy  out  1  high in CLEAR/LOAD/FFT/FREQ
done  out  1  one-cycle pulse on run completion
error  out  1  sticky watchdog flag; cleared by accepted start
stage  out  3  0 idle, 1 load, 2 fft, 3 freq, 4 done, 7 error
load_go  out  1  enable to load_to_mem
load_done  in  1  load_to_mem finished
fft_go  out  1  enable to fft
fft_done  in  1  fft finished
freq_go  out  1  enable to find_freq
freq_done  in  1  find_freq finished
load_addr  in  ADDR_W  load stage address
load_we  in  1  load stage write enable
load_wdata  in  DATA_W  load stage write data
fft_addr  in  ADDR_W  fft stage address
fft_we  in  1  fft stage write enable
fft_wdata  in  DATA_W  fft stage write data
freq_addr  in  ADDR_W  find_freq read address
mem_addr  out  ADDR_W  to memory
mem_we  out  1  to memory
mem_wdata  out  DATA_W  to memory
mem_clr  out  1  active-high memory clear pulse

Behaviour:
- Reset (async, rst=1): state IDLE. All go signals, done, error, mem_clr and the watchdog count = 0. stage=0. busy=0.
- FSM states: IDLE, CLEAR, LOAD, FFT, FREQ, DONE, ERROR. All outputs are registered except the memory mux.
- IDLE: start=1 moves to CLEAR next cycle. Accepted start clears error.
- CLEAR: mem_clr=1 for exactly one cycle, then LOAD.
- Stage states (LOAD, FFT, FREQ):
  - First cycle is a settle cycle with go=0; the mux is already switched.
  - The stage's go is registered high from the second cycle on.
  - The stage's done input is sampled only while its go=1.
  - On done=1: go drops next cycle and the FSM advances (LOAD to FFT to FREQ to DONE).
- Cycle reference: start sampled at edge 0 gives CLEAR in cycle 1, LOAD in cycle 2, load_go=1 in cycle 3.
- A done input asserted outside its own stage, or before go=1, is ignored.
- Watchdog:
  - Counter resets on each stage entry and counts while go=1.
  - If the count reaches TIMEOUT before done, the FSM moves to ERROR. All go signals drop that same edge; error=1; stage=7.
- ERROR: holds until start, which moves to CLEAR.
- DONE: done=1 for one cycle, stage=4, then IDLE (stage back to 0).
- start while busy, or in DONE, is ignored.
- Memory mux (combinational on state):
  - LOAD: load_* signals.
  - FFT: fft_* signals.
  - FREQ: mem_addr=freq_addr, mem_we=0, mem_wdata=0.
  - All other states: addr 0, we 0, wdata 0.
  - mem_we is never high outside LOAD/FFT, including the settle cycle if the stage drives we early.
- Simultaneous done and timeout on the same edge: done wins.

Optional Feature:
SEQ_CONTINUOUS_EN
- Defined: DONE pulses done, then goes to CLEAR instead of IDLE, giving a free-running tuner.
  - A start pulse while busy latches a stop request.
  - With stop latched, the next DONE returns to IDLE and clears the request.
  - ERROR behaviour is unchanged.
- Undefined: single-shot as above; start while busy ignored.

Test Plan:
- Reset then start at cycle 0; stubs return done 5 cycles after go. Required: mem_clr high in cycle 1, load_go high cycles 3–7, stage 1,2,3 in sequence, single done pulse, stage returns to 0, error=0.
- fft_we=1, fft_addr=0x155 driven during LOAD, and load_we=1 driven during FFT. Required: mem_addr and mem_we follow only the owning stage; mem_we=0 throughout FREQ and IDLE.
- TIMEOUT=20, fft_done held 0. Required: ERROR entered exactly 20 cycles after fft_go rose, fft_go low the same edge, error=1, stage=7. A later start clears error and restarts with mem_clr.
- Spurious freq_done=1 during LOAD, and a start pulse during FFT. Required: both ignored, normal completion.
- rst asserted mid-FFT, asynchronous to clk. Required: immediate IDLE, all go=0, mem_we=0, error=0.
- SEQ_CONTINUOUS_EN defined: two runs back-to-back with two done pulses and no IDLE between. A start during run 2 gives IDLE after run 2.
